// File: rtl/control_unit.sv
// control_unit: FETCH/DECODE/EXEC sequencer for a small accumulator CPU.
// Enables are pure decodes of state and ir, so an asynchronous reset drops them at once.
module control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [7:0] instr,
   input  logic       zero_flag,
   output logic [3:0] pc,
   output logic       ce0,
   output logic       ce1,
   output logic       ce2,
   output logic       ce3,
   output logic [1:0] addr,
   output logic [1:0] alu_op,
   output logic       acc_ce,
   output logic       halted
);
   localparam logic [1:0] FETCH  = 2'b00;
   localparam logic [1:0] DECODE = 2'b01;
   localparam logic [1:0] EXEC   = 2'b10;
   localparam logic [1:0] HALT   = 2'b11;
   localparam logic [2:0] OP_LD  = 3'b001;
   localparam logic [2:0] OP_ALU = 3'b010;
   localparam logic [2:0] OP_ST  = 3'b011;
   localparam logic [2:0] OP_IN  = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_JZ  = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   logic [1:0] state;
   logic [7:0] ir;
   logic [2:0] op;
   logic [1:0] rg;
   logic [1:0] fn;
   logic [3:0] imm;
   logic       exec;
   logic       dec_ex;
   logic       st;
   logic [3:0] pc_next;

   assign op     = ir[7:5];
   assign rg     = ir[4:3];
   assign fn     = ir[2:1];
   assign imm    = ir[3:0];
   assign exec   = state == EXEC;
   assign dec_ex = state == DECODE || exec;
   assign st     = exec && op == OP_ST;

   always_comb begin
      addr    = dec_ex ? rg : 2'b00;
      alu_op  = dec_ex ? fn : 2'b00;
      acc_ce  = exec && (op == OP_LD || op == OP_ALU);
      ce0     = st && rg == 2'd0;
      ce1     = st && rg == 2'd1;
      ce2     = st && rg == 2'd2;
      ce3     = exec && op == OP_IN;
      pc_next = (op == OP_JMP || (op == OP_JZ && zero_flag)) ? imm :
                op == OP_HLT ? pc : pc + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FETCH;
         pc     <= 4'd0;
         ir     <= 8'h00;
         halted <= 1'b0;
      end else begin
         case (state)
            FETCH: if (run) begin
               ir    <= instr;
               state <= DECODE;
            end
            DECODE: state <= EXEC;
            EXEC: begin
               pc     <= pc_next;
               state  <= op == OP_HLT ? HALT : FETCH;
               halted <= op == OP_HLT;
            end
            HALT: halted <= 1'b1;
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences with hand-computed enables and pc.
module tb_control_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       zero_flag = 1'b0;
   logic [3:0] pc;
   logic       ce0, ce1, ce2, ce3, acc_ce, halted;
   logic [1:0] addr, alu_op;
   logic [4:0] en;
   int         n_tests = 0;
   int         n_fail = 0;

   control_unit dut (
      .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero_flag(zero_flag),
      .pc(pc), .ce0(ce0), .ce1(ce1), .ce2(ce2), .ce3(ce3),
      .addr(addr), .alu_op(alu_op), .acc_ce(acc_ce), .halted(halted)
   );

   always #5 clk = ~clk;
   assign en = {ce0, ce1, ce2, ce3, acc_ce};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pc"}, {4'h0, pc}, 8'h00);
      chk({tag, " en"}, {3'b0, en}, 8'h00);
      chk({tag, " addr"}, {6'b0, addr}, 8'h00);
      chk({tag, " alu_op"}, {6'b0, alu_op}, 8'h00);
      chk({tag, " halted"}, {7'b0, halted}, 8'h00);
   endtask

   // Starts in FETCH; runs one full instruction and checks every cycle.
   task automatic do_instr(input string tag, input logic [7:0] i, input logic zf,
                           input logic [4:0] exp_en, input logic [3:0] exp_pc);
      logic [3:0] pc0;
      pc0 = pc;
      instr = i;
      run = 1'b1;
      zero_flag = zf;
      chk({tag, " fetch en"}, {3'b0, en}, 8'h00);
      chk({tag, " fetch addr"}, {6'b0, addr}, 8'h00);
      tick;
      chk({tag, " decode en"}, {3'b0, en}, 8'h00);
      chk({tag, " decode addr"}, {6'b0, addr}, {6'b0, i[4:3]});
      chk({tag, " decode alu_op"}, {6'b0, alu_op}, {6'b0, i[2:1]});
      chk({tag, " decode pc"}, {4'h0, pc}, {4'h0, pc0});
      instr = ~i;
      tick;
      chk({tag, " exec en"}, {3'b0, en}, {3'b0, exp_en});
      chk({tag, " exec addr"}, {6'b0, addr}, {6'b0, i[4:3]});
      chk({tag, " exec pc"}, {4'h0, pc}, {4'h0, pc0});
      instr = 8'h00;
      tick;
      chk({tag, " next pc"}, {4'h0, pc}, {4'h0, exp_pc});
      chk({tag, " after en"}, {3'b0, en}, 8'h00);
      chk({tag, " halted"}, {7'b0, halted}, {7'b0, i[7:5] == 3'b111});
   endtask

   initial begin
      #2;
      chk_reset("reset");
      tick;
      chk_reset("reset held");
      rst_n = 1'b1;
      do_instr("LD R0", 8'h20, 1'b0, 5'b00001, 4'd1);
      do_instr("ST R0", 8'h60, 1'b0, 5'b10000, 4'd2);
      do_instr("ST R1", 8'h68, 1'b0, 5'b01000, 4'd3);
      do_instr("ST R2", 8'h70, 1'b0, 5'b00100, 4'd4);
      do_instr("ST R3", 8'h78, 1'b0, 5'b00000, 4'd5);
      do_instr("ALU OR", 8'h46, 1'b0, 5'b00001, 4'd6);
      do_instr("JZ taken", 8'hC9, 1'b1, 5'b00000, 4'd9);
      do_instr("JZ not taken", 8'hC9, 1'b0, 5'b00000, 4'd10);
      do_instr("JMP 15", 8'hAF, 1'b1, 5'b00000, 4'd15);
      do_instr("NOP wrap", 8'h00, 1'b1, 5'b00000, 4'd0);
      do_instr("JMP 5", 8'hA5, 1'b0, 5'b00000, 4'd5);
      instr = 8'h80;
      run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("stall en", {3'b0, en}, 8'h00);
         chk("stall pc", {4'h0, pc}, 8'h05);
         chk("stall addr", {6'b0, addr}, 8'h00);
      end
      do_instr("IN", 8'h80, 1'b0, 5'b00010, 4'd6);
      do_instr("IN rg3", 8'h98, 1'b0, 5'b00010, 4'd7);
      do_instr("HLT", 8'hE0, 1'b0, 5'b00000, 4'd7);
      for (int k = 0; k < 20; k++) begin
         run = k[0];
         instr = 8'h20;
         tick;
         chk("halt pc", {4'h0, pc}, 8'h07);
         chk("halt halted", {7'b0, halted}, 8'h01);
         chk("halt en", {3'b0, en}, 8'h00);
      end
      rst_n = 1'b0;
      #1;
      chk_reset("reset from halt");
      tick;
      rst_n = 1'b1;
      do_instr("LD after halt", 8'h20, 1'b0, 5'b00001, 4'd1);
      instr = 8'h60;
      run = 1'b1;
      tick;
      tick;
      chk("pre-abort ce0", {7'b0, ce0}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("abort in exec");
      tick;
      chk_reset("abort held");
      rst_n = 1'b1;
      do_instr("LD after abort", 8'h28, 1'b0, 5'b00001, 4'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 run  in  1  start/continue; FETCH advances only while run=1.
REQ-005 instr  in  8  program-memory word at address pc; valid combinationally.
REQ-006 zero_flag  in  1  ALU zero result, valid while state=EXEC.
REQ-007 pc  out  4  program counter, registered.
REQ-008 ce0, ce1, ce2, ce3  out  1 each  register-file write enables; ce3 loads switch data.
REQ-009 addr  out  2  register-file read select.
REQ-010 alu_op  out  2  ALU function: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-011 acc_ce  out  1  accumulator load enable.
REQ-012 halted  out  1  high while in HALT.

Function
REQ-013 SHALL hold an 8-bit instruction register ir; fields: op=ir[7:5], rg=ir[4:3], fn=ir[2:1], imm=ir[3:0].
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC and HALT; all other encodings SHALL go to FETCH on the next edge.
REQ-015 FETCH with run=1: ir<=instr, next DECODE; FETCH with run=0: hold state, ir and pc.
REQ-016 DECODE SHALL always go to EXEC after one cycle; each instruction takes exactly 3 cycles.
REQ-017 EXEC SHALL go to FETCH, except op=111, which SHALL go to HALT.
REQ-018 HALT SHALL be left only by reset; run is ignored in HALT.
REQ-019 In DECODE and EXEC, addr SHALL equal rg and alu_op SHALL equal fn; otherwise both SHALL be 00.
REQ-020 ce0-ce3 and acc_ce SHALL be high only during EXEC, for exactly one cycle, and at most one of the five SHALL be high in any cycle.
REQ-021 op 000 NOP: no enable asserted.
REQ-022 op 001 LD: acc_ce=1.
REQ-023 op 010 ALU: acc_ce=1.
REQ-024 op 011 ST: ce[rg]=1 for rg=0..2; for rg=3, no enable is asserted (R3 is switch-only) and the instruction behaves as NOP.
REQ-025 op 100 IN: ce3=1 regardless of rg.
REQ-026 op 101 JMP: on EXEC exit, pc<=imm.
REQ-027 op 110 JZ: on EXEC exit, pc<=imm if zero_flag=1, else pc<=pc+1.
REQ-028 op 111 HLT: pc is unchanged.
REQ-029 All other ops SHALL set pc<=pc+1 on EXEC exit, modulo 16 (15 wraps to 0).
REQ-030 pc SHALL change only on the EXEC-exit edge.
REQ-031 halted SHALL be a registered output, high from the edge entering HALT.
REQ-032 ce*, acc_ce, addr and alu_op SHALL be combinational decodes of state and ir only, glitch-free relative to the clock edge.

Reset
REQ-033 While rst_n=0, and immediately on its assertion, the block SHALL set state=FETCH, pc=0, ir=0x00, all ce*=0, acc_ce=0, addr=00, alu_op=00 and halted=0.
REQ-034 Reset asserted mid-EXEC SHALL drop all enables at once, with no write completing.
REQ-035 The first FETCH SHALL occur on the first rising edge after rst_n rises with run=1.

Verification
REQ-036 Reset, run=1, pc=0 instr=0x20 (LD R0): cycle 1 FETCH, cycles 2-3 addr=00; acc_ce=1 only in cycle 3; pc becomes 1 after cycle 3.
REQ-037 ST to each register, instr=0x60/0x68/0x70/0x78: ce0, ce1 and ce2 pulse once respectively; 0x78 asserts no enable and pc still increments.
REQ-038 JMP and wrap: instr=0xA5 at pc=0 -> pc=5; NOPs from pc=15 -> pc wraps to 0.
REQ-039 JZ instr=0xC9: zero_flag=1 in EXEC -> pc=9; zero_flag=0 -> pc=pc+1.
REQ-040 HLT instr=0xE0 -> halted=1 and pc frozen for 20 cycles with run toggling; rst_n=0 -> all outputs return to reset values.
REQ-041 IN instr=0x80 with run dropped to 0 in FETCH: the block stalls with no enables; after run=1, ce3 pulses exactly once in EXEC.
